// File: rtl/namuru_dump_buffer_pkg.sv
// Shared definitions for the per-channel dump buffer: entry layout, field offsets and defaults.
// The ctlif read-out mux reuses these offsets to slice rd_data.
package namuru_dump_buffer_pkg;

  localparam int ACC_W   = 16;
  localparam int EPOCH_W = 11;
  localparam int ENTRY_W = EPOCH_W + 6 * ACC_W;

  localparam int EPOCH_MSB    = 106;
  localparam int EPOCH_LSB    = 96;
  localparam int I_EARLY_MSB  = 95;
  localparam int I_EARLY_LSB  = 80;
  localparam int Q_EARLY_MSB  = 79;
  localparam int Q_EARLY_LSB  = 64;
  localparam int I_PROMPT_MSB = 63;
  localparam int I_PROMPT_LSB = 48;
  localparam int Q_PROMPT_MSB = 47;
  localparam int Q_PROMPT_LSB = 32;
  localparam int I_LATE_MSB   = 31;
  localparam int I_LATE_LSB   = 16;
  localparam int Q_LATE_MSB   = 15;
  localparam int Q_LATE_LSB   = 0;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_OVF_W = 8;

  // Field order matches the offsets above: epoch lands in the top bits.
  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [ACC_W-1:0]   i_early;
    logic [ACC_W-1:0]   q_early;
    logic [ACC_W-1:0]   i_prompt;
    logic [ACC_W-1:0]   q_prompt;
    logic [ACC_W-1:0]   i_late;
    logic [ACC_W-1:0]   q_late;
  } entry_t;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/namuru_dump_buffer_if.sv
// Bundle between tracking channel/software (master) and the dump buffer (slave).
interface namuru_dump_buffer_if
  import namuru_dump_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OVF_W = DEFAULT_OVF_W
);
  localparam int LVL_W = level_width(DEPTH);

  logic               dump;
  logic [ACC_W-1:0]   i_early;
  logic [ACC_W-1:0]   q_early;
  logic [ACC_W-1:0]   i_prompt;
  logic [ACC_W-1:0]   q_prompt;
  logic [ACC_W-1:0]   i_late;
  logic [ACC_W-1:0]   q_late;
  logic [EPOCH_W-1:0] epoch;
  logic               accum_enable;
  logic               clear;
  logic               rd_ready;
  logic               irq_ack;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [LVL_W-1:0]   level;
  logic [OVF_W-1:0]   overflow_cnt;
  logic               accum_irq;

  modport master (
    output dump, i_early, q_early, i_prompt, q_prompt, i_late, q_late, epoch,
    output accum_enable, clear, rd_ready, irq_ack,
    input  rd_valid, rd_data, level, overflow_cnt, accum_irq
  );

  modport slave (
    input  dump, i_early, q_early, i_prompt, q_prompt, i_late, q_late, epoch,
    input  accum_enable, clear, rd_ready, irq_ack,
    output rd_valid, rd_data, level, overflow_cnt, accum_irq
  );

endinterface

// File: rtl/namuru_sync_fifo.sv
// Show-ahead synchronous FIFO with level output; pushes into a full FIFO are dropped
// unless a pop happens in the same cycle. Full/empty come from the level count.
module namuru_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next,
  output logic             dropped
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg;
  logic             empty, full, pop_ok, push_ok;

  always_comb begin
    empty   = (level_reg == '0);
    full    = (level_reg == LVL_W'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    dropped = push && !push_ok;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push_ok) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_reg] <= push_data;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
  assign level    = level_reg;

endmodule

// File: rtl/namuru_dump_buffer.sv
// Per-channel dump capture: packs accumulators + epoch into the FIFO, counts dropped
// dumps (saturating) and raises a sticky accumulation interrupt.
module namuru_dump_buffer
  import namuru_dump_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OVF_W = DEFAULT_OVF_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  namuru_dump_buffer_if.slave  bus
);

  localparam int LVL_W = level_width(DEPTH);

  entry_t           entry;
  logic [LVL_W-1:0] level_next;
  logic             dropped;
  logic [OVF_W-1:0] overflow_reg, overflow_next;
  logic             irq_reg, irq_next;

  always_comb begin
    entry.epoch    = bus.epoch;
    entry.i_early  = bus.i_early;
    entry.q_early  = bus.q_early;
    entry.i_prompt = bus.i_prompt;
    entry.q_prompt = bus.q_prompt;
    entry.i_late   = bus.i_late;
    entry.q_late   = bus.q_late;
  end

  namuru_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (bus.clear),
    .push       (bus.dump),
    .push_data  (entry),
    .pop        (bus.rd_ready),
    .rd_valid   (bus.rd_valid),
    .rd_data    (bus.rd_data),
    .level      (bus.level),
    .level_next (level_next),
    .dropped    (dropped)
  );

  always_comb begin
    overflow_next = overflow_reg;
    irq_next      = irq_reg;
    if (bus.clear) begin
      overflow_next = '0;
      irq_next      = 1'b0;
    end else begin
      if (dropped && (overflow_reg != '1)) overflow_next = overflow_reg + OVF_W'(1);
      // A new strobe outranks a simultaneous acknowledge so no dump goes unannounced.
      if (bus.accum_enable && (level_next != '0)) irq_next = 1'b1;
      else if (bus.irq_ack)                       irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      overflow_reg <= overflow_next;
      irq_reg      <= irq_next;
    end
  end

  assign bus.overflow_cnt = overflow_reg;
  assign bus.accum_irq    = irq_reg;

endmodule

// File: tb/tb_namuru_dump_buffer.sv
// Directed bench for namuru_dump_buffer (DEPTH=4, OVF_W=8).
module tb_namuru_dump_buffer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   passed = 0;
  int   total = 0;

  namuru_dump_buffer_if #(.DEPTH(4), .OVF_W(8)) bus ();

  namuru_dump_buffer #(.DEPTH(4), .OVF_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dump = 0; bus.accum_enable = 0; bus.clear = 0; bus.rd_ready = 0; bus.irq_ack = 0;
    bus.i_early = 0; bus.q_early = 0; bus.i_prompt = 0; bus.q_prompt = 0;
    bus.i_late = 0; bus.q_late = 0; bus.epoch = 0;
  endtask

  task automatic push_one(input logic [10:0] ep, input logic [15:0] ie);
    bus.dump = 1; bus.epoch = ep; bus.i_early = ie; bus.q_early = ~ie;
    bus.i_prompt = ie ^ 16'h5A5A; bus.q_prompt = 16'h0F0F; bus.i_late = ie + 16'd1; bus.q_late = 16'hC3C3;
    tick();
    bus.dump = 0;
  endtask

  task automatic pop_one();
    bus.rd_ready = 1;
    tick();
    bus.rd_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); else passed++;
    total++; if (bus.level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", bus.level); else passed++;
    tick(); rstn = 1; tick();
    push_one(11'd1, 16'h0001); push_one(11'd2, 16'h0002); push_one(11'd3, 16'h0003);
    bus.accum_enable = 1; tick(); bus.accum_enable = 0;
    total++; if (bus.level !== 3'd3) $display("FAIL pre_reset_level got=%0d exp=3", bus.level); else passed++;
    #2 rstn = 0; #1;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data !== 107'd0) $display("FAIL mid_reset_data got=%h exp=0", bus.rd_data); else passed++;
    total++; if (bus.level !== 3'd0) $display("FAIL mid_reset_level got=%0d exp=0", bus.level); else passed++;
    total++; if (bus.accum_irq !== 1'b0) $display("FAIL mid_reset_irq got=%b exp=0", bus.accum_irq); else passed++;
    total++; if (bus.overflow_cnt !== 8'd0) $display("FAIL mid_reset_ovf got=%0d exp=0", bus.overflow_cnt); else passed++;
    @(posedge clk); #1 rstn = 1; tick();
    $display("test_reset done: %0d/%0d", passed, total);
  endtask

  task automatic test_single();
    logic [106:0] exp_data;
    exp_data = {11'h3FF, 16'h8001, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    bus.dump = 1; bus.epoch = 11'h3FF; bus.i_early = 16'h8001; bus.q_early = 16'h1234;
    bus.i_prompt = 16'h7FFF; bus.q_prompt = 16'h8000; bus.i_late = 16'hFFFF; bus.q_late = 16'h0001;
    #1;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", bus.rd_valid); else passed++;
    tick(); bus.dump = 0;
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.rd_valid); else passed++;
    total++; if (bus.rd_data[106:96] !== 11'h3FF) $display("FAIL single_epoch got=%h exp=3ff", bus.rd_data[106:96]); else passed++;
    total++; if (bus.rd_data[95:80] !== 16'h8001) $display("FAIL single_ie got=%h exp=8001", bus.rd_data[95:80]); else passed++;
    total++; if (bus.rd_data !== exp_data) $display("FAIL single_data got=%h exp=%h", bus.rd_data, exp_data); else passed++;
    pop_one();
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL single_pop_valid got=%b exp=0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data !== 107'd0) $display("FAIL single_pop_data got=%h exp=0", bus.rd_data); else passed++;
    $display("test_single done: %0d/%0d", passed, total);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) push_one(11'(k), 16'(k * 16'h0111));
    total++; if (bus.level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", bus.level); else passed++;
    total++; if (bus.overflow_cnt !== 8'd1) $display("FAIL ovf_cnt got=%0d exp=1", bus.overflow_cnt); else passed++;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus.rd_data[106:96] !== 11'(k)) $display("FAIL ovf_pop%0d_epoch got=%0d exp=%0d", k, bus.rd_data[106:96], k); else passed++;
      total++; if (bus.rd_data[95:80] !== 16'(k * 16'h0111)) $display("FAIL ovf_pop%0d_ie got=%h exp=%h", k, bus.rd_data[95:80], 16'(k * 16'h0111)); else passed++;
      pop_one();
    end
    pop_one();
    total++; if (bus.level !== 3'd0) $display("FAIL empty_pop_level got=%0d exp=0", bus.level); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL empty_pop_valid got=%b exp=0", bus.rd_valid); else passed++;
    $display("test_overflow done: %0d/%0d", passed, total);
  endtask

  task automatic test_full_push_pop();
    for (int k = 10; k <= 13; k++) push_one(11'(k), 16'(k));
    bus.rd_ready = 1;
    push_one(11'd14, 16'h0E0E);
    bus.rd_ready = 0;
    total++; if (bus.level !== 3'd4) $display("FAIL fpp_level got=%0d exp=4", bus.level); else passed++;
    total++; if (bus.overflow_cnt !== 8'd1) $display("FAIL fpp_ovf got=%0d exp=1", bus.overflow_cnt); else passed++;
    for (int k = 11; k <= 14; k++) begin
      total++; if (bus.rd_data[106:96] !== 11'(k)) $display("FAIL fpp_head epoch got=%0d exp=%0d", bus.rd_data[106:96], k); else passed++;
      pop_one();
    end
    total++; if (bus.level !== 3'd0) $display("FAIL fpp_drain_level got=%0d exp=0", bus.level); else passed++;
    $display("test_full_push_pop done: %0d/%0d", passed, total);
  endtask

  task automatic test_irq();
    push_one(11'd20, 16'h0020); push_one(11'd21, 16'h0021);
    total++; if (bus.accum_irq !== 1'b0) $display("FAIL irq_idle got=%b exp=0", bus.accum_irq); else passed++;
    bus.accum_enable = 1; tick(); bus.accum_enable = 0;
    total++; if (bus.accum_irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", bus.accum_irq); else passed++;
    bus.accum_enable = 1; bus.irq_ack = 1; tick(); bus.accum_enable = 0; bus.irq_ack = 0;
    total++; if (bus.accum_irq !== 1'b1) $display("FAIL irq_set_wins got=%b exp=1", bus.accum_irq); else passed++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    total++; if (bus.accum_irq !== 1'b0) $display("FAIL irq_ack got=%b exp=0", bus.accum_irq); else passed++;
    bus.accum_enable = 1; tick(); bus.accum_enable = 0;
    pop_one(); pop_one();
    total++; if (bus.accum_irq !== 1'b1) $display("FAIL irq_sticky got=%b exp=1", bus.accum_irq); else passed++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    bus.accum_enable = 1; tick(); bus.accum_enable = 0;
    total++; if (bus.accum_irq !== 1'b0) $display("FAIL irq_empty got=%b exp=0", bus.accum_irq); else passed++;
    $display("test_irq done: %0d/%0d", passed, total);
  endtask

  task automatic test_clear();
    for (int k = 0; k < 304; k++) push_one(11'(k), 16'(k));
    total++; if (bus.overflow_cnt !== 8'd255) $display("FAIL clr_pre_ovf got=%0d exp=255", bus.overflow_cnt); else passed++;
    bus.accum_enable = 1; tick(); bus.accum_enable = 0;
    total++; if (bus.accum_irq !== 1'b1) $display("FAIL clr_pre_irq got=%b exp=1", bus.accum_irq); else passed++;
    bus.clear = 1; bus.rd_ready = 1; bus.accum_enable = 1;
    push_one(11'h555, 16'hAAAA);
    bus.clear = 0; bus.rd_ready = 0; bus.accum_enable = 0;
    total++; if (bus.level !== 3'd0) $display("FAIL clr_level got=%0d exp=0", bus.level); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL clr_valid got=%b exp=0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data !== 107'd0) $display("FAIL clr_data got=%h exp=0", bus.rd_data); else passed++;
    total++; if (bus.overflow_cnt !== 8'd0) $display("FAIL clr_ovf got=%0d exp=0", bus.overflow_cnt); else passed++;
    total++; if (bus.accum_irq !== 1'b0) $display("FAIL clr_irq got=%b exp=0", bus.accum_irq); else passed++;
    tick();
    total++; if (bus.level !== 3'd0) $display("FAIL clr_after_level got=%0d exp=0", bus.level); else passed++;
    for (int k = 0; k < 300; k++) push_one(11'(k), 16'(k));
    total++; if (bus.level !== 3'd4) $display("FAIL sat_level got=%0d exp=4", bus.level); else passed++;
    total++; if (bus.overflow_cnt !== 8'd255) $display("FAIL sat_ovf got=%0d exp=255", bus.overflow_cnt); else passed++;
    total++; if (bus.rd_data[106:96] !== 11'd0) $display("FAIL sat_head got=%0d exp=0", bus.rd_data[106:96]); else passed++;
    $display("test_clear done: %0d/%0d", passed, total);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
